// File: rtl/tr_sequencer.sv
// T/R switching sequencer: orders relay, PA bias and RF enable on key-down and the reverse on key-up,
// with programmable tick-based settle delays, receiver mute and a latched TX watchdog.
module tr_sequencer #(
    parameter int unsigned TICK_DIV   = 25,
    parameter logic [5:0]  CMD_ADDR   = 6'h2E,
    parameter int unsigned MS_DIV     = 2500,
    parameter int unsigned MS_PER_SEC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_rqst,
    input  logic        tx_req,
    input  logic        tx_inhibit,
    input  logic        pa_enable,
    input  logic        vna,
    output logic        pa_tr,
    output logic        pa_bias_en,
    output logic        tx_rf_en,
    output logic        rx_mute,
    output logic        fault,
    output logic [2:0]  seq_state
);

    localparam int unsigned CNT_W = $clog2(255 * TICK_DIV + 1);
    localparam int unsigned PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int unsigned MSC_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;

    localparam logic [7:0] RELAY_RST = 8'd20;
    localparam logic [7:0] BIAS_RST  = 8'd5;
    localparam logic [7:0] TAIL_RST  = 8'd10;
    localparam logic [7:0] WD_RST    = 8'd0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEYRELAY = 3'd1,
        S_KEYBIAS  = 3'd2,
        S_TX       = 3'd3,
        S_TAIL     = 3'd4,
        S_UNBIAS   = 3'd5,
        S_RELEASE  = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_relay_dly;
    logic [7:0]         r_bias_dly;
    logic [7:0]         r_tail_dly;
    logic [7:0]         r_wd_sec;
    logic [CNT_W-1:0]   r_cnt;
    logic [PRE_W-1:0]   r_ms_pre;
    logic [MSC_W-1:0]   r_ms_cnt;
    logic [7:0]         r_sec;

    logic               w_req_eff;
    logic               w_use_pa;
    logic               w_done;
    logic               w_ms_tick;
    logic               w_sec_tick;
    logic [7:0]         w_sec_nxt;
    logic               w_wd_exp;
    logic               w_fault_set;
    logic [7:0]         w_dly_sel;
    logic [CNT_W-1:0]   w_dly_cyc;
    logic [CNT_W-1:0]   w_cnt_load;
    logic               w_tr;
    logic               w_bias;
    logic               w_rf;
    logic               w_mute;
    logic               w_cfg_wr;

    assign w_req_eff  = tx_req & ~tx_inhibit & ~fault;
    assign w_use_pa   = pa_enable & ~vna;
    assign w_done     = (r_cnt == '0);
    assign w_cfg_wr   = cmd_rqst && (cmd_addr == CMD_ADDR);
    assign seq_state  = r_state;

    // Watchdog: ms prescaler and second counter; expiry looks at the count this edge produces.
    assign w_ms_tick  = (r_ms_pre == PRE_W'(MS_DIV - 1));
    assign w_sec_tick = w_ms_tick && (r_ms_cnt == MSC_W'(MS_PER_SEC - 1));
    assign w_sec_nxt  = (w_sec_tick && (r_sec != 8'hFF)) ? r_sec + 8'd1 : r_sec;
    assign w_wd_exp   = (r_wd_sec != 8'd0) && (w_sec_nxt >= r_wd_sec);

    // Next-state logic; request aborts win over dwell completion.
    always_comb begin
        w_state_nxt = r_state;
        w_fault_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_eff) w_state_nxt = S_KEYRELAY;
            end
            S_KEYRELAY: begin
                if (!w_req_eff)  w_state_nxt = S_RELEASE;
                else if (w_done) w_state_nxt = S_KEYBIAS;
            end
            S_KEYBIAS: begin
                if (!w_req_eff)                w_state_nxt = S_UNBIAS;
                else if (w_done || !w_use_pa)  w_state_nxt = S_TX;
            end
            S_TX: begin
                if (!w_req_eff) begin
                    w_state_nxt = S_TAIL;
                end else if (w_wd_exp) begin
                    w_state_nxt = S_TAIL;
                    w_fault_set = 1'b1;
                end
            end
            S_TAIL: begin
                if (w_req_eff)   w_state_nxt = S_TX;
                else if (w_done) w_state_nxt = S_UNBIAS;
            end
            S_UNBIAS: begin
                if (w_req_eff)                 w_state_nxt = S_KEYBIAS;
                else if (w_done || !w_use_pa)  w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (w_req_eff)   w_state_nxt = S_KEYRELAY;
                else if (w_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode and dwell load value for the state being entered.
    always_comb begin
        w_tr      = 1'b0;
        w_bias    = 1'b0;
        w_rf      = 1'b0;
        w_mute    = 1'b0;
        w_dly_sel = 8'd0;
        case (w_state_nxt)
            S_KEYRELAY: begin w_tr = 1'b1; w_mute = 1'b1; w_dly_sel = r_relay_dly; end
            S_KEYBIAS:  begin w_tr = 1'b1; w_bias = 1'b1; w_mute = 1'b1; w_dly_sel = r_bias_dly; end
            S_TX:       begin w_tr = 1'b1; w_bias = 1'b1; w_rf = 1'b1; w_mute = 1'b1; end
            S_TAIL:     begin w_tr = 1'b1; w_bias = 1'b1; w_mute = 1'b1; w_dly_sel = r_tail_dly; end
            S_UNBIAS:   begin w_tr = 1'b1; w_mute = 1'b1; w_dly_sel = r_bias_dly; end
            S_RELEASE:  begin w_mute = 1'b1; w_dly_sel = r_relay_dly; end
            default:    ;
        endcase
    end

    assign w_dly_cyc  = CNT_W'(w_dly_sel) * CNT_W'(TICK_DIV);
    assign w_cnt_load = (w_dly_cyc == '0) ? '0 : w_dly_cyc - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dwell counter reloads on every state entry, so the tick phase restarts each time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= w_cnt_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_TX) || (w_state_nxt != S_TX)) begin
            r_ms_pre <= '0;
            r_ms_cnt <= '0;
            r_sec    <= 8'd0;
        end else begin
            r_ms_pre <= w_ms_tick ? '0 : r_ms_pre + PRE_W'(1);
            if (w_ms_tick) begin
                r_ms_cnt <= w_sec_tick ? '0 : r_ms_cnt + MSC_W'(1);
            end
            r_sec <= w_sec_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_relay_dly <= RELAY_RST;
            r_bias_dly  <= BIAS_RST;
            r_tail_dly  <= TAIL_RST;
            r_wd_sec    <= WD_RST;
        end else if (w_cfg_wr) begin
            r_relay_dly <= cmd_data[7:0];
            r_bias_dly  <= cmd_data[15:8];
            r_tail_dly  <= cmd_data[23:16];
            r_wd_sec    <= cmd_data[31:24];
        end
    end

    // Gated, registered drive outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            pa_tr      <= 1'b0;
            pa_bias_en <= 1'b0;
            tx_rf_en   <= 1'b0;
            rx_mute    <= 1'b0;
        end else begin
            pa_tr      <= w_tr & ~vna;
            pa_bias_en <= w_bias & w_use_pa;
            tx_rf_en   <= w_rf;
            rx_mute    <= w_mute;
        end
    end

    // Fault latches on expiry and releases only once the operator lets go of the request.
    always_ff @(posedge clk) begin
        if (rst || !tx_req) begin
            fault <= 1'b0;
        end else if (w_fault_set) begin
            fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tr_sequencer.sv
// Directed bench for tr_sequencer: expectations are queued with their cycle when stimulus is driven
// and checked against {seq_state, pa_tr, pa_bias_en, tx_rf_en, rx_mute, fault} at the falling edge.
module tb_tr_sequencer;

    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_KR   = 5'b10010;
    localparam logic [4:0] O_KB   = 5'b11010;
    localparam logic [4:0] O_TX   = 5'b11110;
    localparam logic [4:0] O_TAIL = 5'b11010;
    localparam logic [4:0] O_UNB  = 5'b10010;
    localparam logic [4:0] O_REL  = 5'b00010;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_rqst;
    logic        tx_req;
    logic        tx_inhibit;
    logic        pa_enable;
    logic        vna;
    logic        pa_tr;
    logic        pa_bias_en;
    logic        tx_rf_en;
    logic        rx_mute;
    logic        fault;
    logic [2:0]  seq_state;
    logic [7:0]  obs;

    typedef struct {
        int         cyc;
        logic [7:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Second = 100 clocks so the watchdog path fits in a short run.
    tr_sequencer #(
        .TICK_DIV   (25),
        .CMD_ADDR   (6'h2E),
        .MS_DIV     (10),
        .MS_PER_SEC (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_rqst   (cmd_rqst),
        .tx_req     (tx_req),
        .tx_inhibit (tx_inhibit),
        .pa_enable  (pa_enable),
        .vna        (vna),
        .pa_tr      (pa_tr),
        .pa_bias_en (pa_bias_en),
        .tx_rf_en   (tx_rf_en),
        .rx_mute    (rx_mute),
        .fault      (fault),
        .seq_state  (seq_state)
    );

    assign obs = {seq_state, pa_tr, pa_bias_en, tx_rf_en, rx_mute, fault};

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            checks++;
            assert (obs === m_e.v && m_e.cyc == cyc) else begin
                errors++;
                $error("FAIL %s at cyc %0d (due %0d): observed %b expected %b", m_e.tag, cyc, m_e.cyc, obs, m_e.v);
            end
        end
    end

    task automatic expect_at(input string tag, input int c, input logic [2:0] st, input logic [4:0] o);
        exp_t e;
        e.cyc = c;
        e.v   = {st, o};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
        cmd_addr = a;
        cmd_data = d;
        cmd_rqst = 1'b1;
        @(posedge clk);
        #1;
        cmd_rqst = 1'b0;
    endtask

    initial begin
        int e, f, g, t, c, k, guard;
        rst = 1'b1; cmd_addr = 6'h00; cmd_data = 32'h0; cmd_rqst = 1'b0;
        tx_req = 1'b0; tx_inhibit = 1'b0; pa_enable = 1'b1; vna = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_at("rst_hold", cyc, 3'd0, O_IDLE);
        rst = 1'b0;
        expect_at("rst_idle", cyc + 1, 3'd0, O_IDLE);
        goto(cyc + 2);

        // Default timing with PA fitted, VNA gating in TX, full release.
        tx_req = 1'b1; e = cyc + 1;
        expect_at("kd_relay",     e,       3'd1, O_KR);
        expect_at("kd_relay_end", e + 499, 3'd1, O_KR);
        expect_at("kd_bias",      e + 500, 3'd2, O_KB);
        expect_at("kd_bias_end",  e + 624, 3'd2, O_KB);
        expect_at("kd_tx",        e + 625, 3'd3, O_TX);
        goto(e + 650);
        vna = 1'b1;
        expect_at("vna_gate", cyc + 1, 3'd3, 5'b00110);
        goto(cyc + 1);
        vna = 1'b0;
        expect_at("vna_ungate", cyc + 1, 3'd3, O_TX);
        goto(e + 700);
        tx_req = 1'b0; f = cyc + 1;
        expect_at("ku_tail",     f,       3'd4, O_TAIL);
        expect_at("ku_tail_end", f + 249, 3'd4, O_TAIL);
        expect_at("ku_unbias",   f + 250, 3'd5, O_UNB);
        expect_at("ku_release",  f + 375, 3'd6, O_REL);
        expect_at("ku_rel_end",  f + 874, 3'd6, O_REL);
        expect_at("ku_idle",     f + 875, 3'd0, O_IDLE);
        goto(f + 880);

        // Wrong address must not change config; PA absent skips the bias dwell.
        cfg_write(6'h2D, 32'h0);
        pa_enable = 1'b0;
        tx_req = 1'b1; e = cyc + 1;
        expect_at("nopa_relay",    e,       3'd1, O_KR);
        expect_at("nopa_relay_e",  e + 499, 3'd1, O_KR);
        expect_at("nopa_bias",     e + 500, 3'd2, 5'b10010);
        expect_at("nopa_tx",       e + 501, 3'd3, 5'b10110);
        goto(e + 520);
        tx_req = 1'b0; f = cyc + 1;
        expect_at("nopa_tail",    f,       3'd4, 5'b10010);
        expect_at("nopa_unbias",  f + 250, 3'd5, O_UNB);
        expect_at("nopa_release", f + 251, 3'd6, O_REL);
        expect_at("nopa_idle",    f + 751, 3'd0, O_IDLE);
        goto(f + 755);
        pa_enable = 1'b1;

        // Abort in KEYRELAY.
        tx_req = 1'b1; e = cyc + 1;
        expect_at("ab_relay", e, 3'd1, O_KR);
        goto(e + 100);
        tx_req = 1'b0; f = cyc + 1;
        expect_at("ab_release", f,       3'd6, O_REL);
        expect_at("ab_rel_end", f + 499, 3'd6, O_REL);
        expect_at("ab_idle",    f + 500, 3'd0, O_IDLE);
        goto(f + 505);

        // Re-key during TAIL returns straight to TX with bias held.
        tx_req = 1'b1; e = cyc + 1;
        expect_at("rk_tx", e + 625, 3'd3, O_TX);
        goto(e + 650);
        tx_req = 1'b0; f = cyc + 1;
        expect_at("rk_tail", f, 3'd4, O_TAIL);
        goto(f + 50);
        tx_req = 1'b1; g = cyc + 1;
        expect_at("rk_tail_hold", g - 1, 3'd4, O_TAIL);
        expect_at("rk_tx_again",  g,     3'd3, O_TX);
        goto(g + 5);
        tx_req = 1'b0; f = cyc + 1;
        expect_at("rk_idle", f + 875, 3'd0, O_IDLE);
        goto(f + 880);

        // Watchdog: 1 second, held key.
        cfg_write(6'h2E, {8'd1, 8'd10, 8'd5, 8'd20});
        tx_req = 1'b1; e = cyc + 1; t = e + 625;
        expect_at("wd_tx",      t,       3'd3, O_TX);
        expect_at("wd_tx_last", t + 99,  3'd3, O_TX);
        expect_at("wd_expire",  t + 100, 3'd4, 5'b11011);
        expect_at("wd_unbias",  t + 350, 3'd5, 5'b10011);
        expect_at("wd_release", t + 475, 3'd6, 5'b00011);
        expect_at("wd_idle",    t + 975, 3'd0, 5'b00001);
        expect_at("wd_hold",    t + 1000, 3'd0, 5'b00001);
        goto(t + 1000);
        tx_req = 1'b0;
        expect_at("wd_clear", cyc + 1, 3'd0, O_IDLE);
        goto(cyc + 3);

        // All-zero config gives single-cycle dwells; inhibit drops out of TX.
        cfg_write(6'h2E, 32'h0000_0000);
        tx_req = 1'b1; e = cyc + 1;
        expect_at("z_relay", e,     3'd1, O_KR);
        expect_at("z_bias",  e + 1, 3'd2, O_KB);
        expect_at("z_tx",    e + 2, 3'd3, O_TX);
        goto(e + 10);
        tx_inhibit = 1'b1; c = cyc + 1;
        expect_at("inh_tail",    c,     3'd4, O_TAIL);
        expect_at("inh_unbias",  c + 1, 3'd5, O_UNB);
        expect_at("inh_release", c + 2, 3'd6, O_REL);
        expect_at("inh_idle",    c + 3, 3'd0, O_IDLE);
        expect_at("inh_stay",    c + 6, 3'd0, O_IDLE);
        goto(c + 6);
        tx_req = 1'b0; tx_inhibit = 1'b0;
        goto(cyc + 2);

        // Reset in TX: hard drop, then default timing is back.
        tx_req = 1'b1; e = cyc + 1;
        expect_at("r_tx", e + 2, 3'd3, O_TX);
        goto(e + 5);
        rst = 1'b1;
        expect_at("r_drop", cyc + 1, 3'd0, O_IDLE);
        goto(cyc + 1);
        rst = 1'b0; k = cyc + 1;
        expect_at("r_relay",     k,       3'd1, O_KR);
        expect_at("r_relay_end", k + 499, 3'd1, O_KR);
        expect_at("r_bias",      k + 500, 3'd2, O_KB);
        expect_at("r_tx_again",  k + 625, 3'd3, O_TX);
        goto(k + 630);
        tx_req = 1'b0; f = cyc + 1;
        expect_at("r_tail", f,       3'd4, O_TAIL);
        expect_at("r_idle", f + 875, 3'd0, O_IDLE);
        goto(f + 880);

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
